d_trigger_arbiter: RTL and testbench

D_TRIGGER_ARBITER -- requirements
Module: d_trigger_arbiter

---
 rtl/d_trigger_arbiter_if.sv | 14 +
 rtl/d_trigger_arbiter.sv | 89 ++++++++
 tb/tb_d_trigger_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/d_trigger_arbiter_if.sv
// Bundle between four requesters and the shared-word arbiter.
// Handshake: a requester holds req[i] with a stable data slice until ack[i] pulses; dropping req[i] while gnt[i] is high cancels the write.
interface d_trigger_arbiter_if #(parameter int WIDTH = 4);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data;
  logic [3:0]         gnt;
  logic [3:0]         ack;
  logic [WIDTH-1:0]   q;
  logic [1:0]         owner;
  logic               busy;

  modport master (output req, data, input gnt, ack, q, owner, busy);
  modport slave  (input req, data, output gnt, ack, q, owner, busy);
endinterface

// File: rtl/d_trigger_arbiter.sv
// Round-robin arbiter for four writers sharing one stored word.
// One write takes three states: IDLE picks the winner, GRANT commits, ACK pulses.
module d_trigger_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  d_trigger_arbiter_if.slave    bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] wsel;
  logic [1:0] win;
  logic       found;
  logic [1:0] idx;

  // First requester at or after ptr, wrapping modulo four.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      wsel      <= 2'd0;
      bus.gnt   <= 4'd0;
      bus.ack   <= 4'd0;
      bus.q     <= '0;
      bus.owner <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.ack <= 4'd0;
          if (found) begin
            bus.gnt <= 4'b0001 << win;
            wsel    <= win;
            state   <= GRANT;
          end else begin
            bus.gnt <= 4'd0;
          end
        end
        GRANT: begin
          bus.gnt <= 4'd0;
          // A winner that dropped its request forfeits the slot without touching ptr.
          if (bus.req[wsel]) begin
            bus.q     <= bus.data[int'(wsel)*WIDTH +: WIDTH];
            bus.owner <= wsel;
            bus.ack   <= 4'b0001 << wsel;
            ptr       <= wsel + 2'd1;
            state     <= ACK;
          end else begin
            state     <= IDLE;
          end
        end
        ACK: begin
          bus.ack <= 4'd0;
          state   <= IDLE;
        end
        default: begin
          bus.gnt <= 4'd0;
          bus.ack <= 4'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_d_trigger_arbiter.sv
// Randomized and directed checks of d_trigger_arbiter against a transaction-level model.
module tb_d_trigger_arbiter;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  d_trigger_arbiter_if #(.WIDTH(W)) bus();

  d_trigger_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_owner[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: phase 0 = waiting, 1 = a winner holds the grant, 2 = write done
  int           m_phase;
  int           m_ptr;
  int           m_win;
  logic [W-1:0] m_q;
  int           m_owner;
  logic [3:0]   m_gnt;
  logic [3:0]   m_ack;

  function automatic void model_reset();
    m_phase = 0; m_ptr = 0; m_win = 0; m_q = '0; m_owner = 0; m_gnt = 0; m_ack = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic [4*W-1:0] d);
    logic [4*W-1:0] sh;
    if (m_phase == 0) begin
      m_ack = 0;
      m_gnt = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (r[c] && m_gnt == 0) begin
          m_win = c;
          m_gnt = 4'(1 << c);
        end
      end
      if (m_gnt != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      m_gnt = 0;
      if (r[m_win]) begin
        sh      = d >> (m_win * W);
        m_q     = sh[W-1:0];
        m_owner = m_win;
        m_ack   = 4'(1 << m_win);
        m_ptr   = (m_win + 1) % 4;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_ack   = 0;
      m_phase = 0;
    end
  endfunction

  task automatic check_all();
    logic [3:0] g;
    logic [3:0] a;
    g = bus.gnt;
    a = bus.ack;
    chk("gnt",   32'(bus.gnt),   32'(m_gnt));
    chk("ack",   32'(bus.ack),   32'(m_ack));
    chk("q",     32'(bus.q),     32'(m_q));
    chk("owner", 32'(bus.owner), 32'(m_owner));
    chk("busy",  32'(bus.busy),  32'(m_phase != 0));
    chk("onehot_excl", 32'(((g & (g - 4'd1)) == 0) && ((a & (a - 4'd1)) == 0) && !(g != 0 && a != 0)), 32'd1);
  endtask

  // driver: one clock, model advanced with the inputs seen at the edge
  task automatic cycle();
    @(posedge clk);
    model_step(bus.req, bus.data);
    #1;
    check_all();
    if (bus.ack != 0 && exp_q.size() > 0) begin
      chk("sb_q",     32'(bus.q),     32'(exp_q.pop_front()));
      chk("sb_owner", 32'(bus.owner), 32'(exp_owner.pop_front()));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = 4'd0;
    bus.data = '0;
    #1;
    model_reset();
    chk("rst_gnt",   32'(bus.gnt),   32'd0);
    chk("rst_ack",   32'(bus.ack),   32'd0);
    chk("rst_q",     32'(bus.q),     32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b1;
    bus.req  = 4'd0;
    bus.data = '0;
    model_reset();
    do_reset();

    // single request
    bus.req  = 4'b0001;
    bus.data = 16'h000A;
    cycle();
    chk("single_gnt", 32'(bus.gnt), 32'h1);
    cycle();
    chk("single_q",   32'(bus.q),   32'hA);
    chk("single_ack", 32'(bus.ack), 32'h1);
    bus.req = 4'd0;
    cycle();
    chk("single_busy", 32'(bus.busy), 32'd0);
    cycle();

    // full contention, slice i holds i+1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(W'((i % 4) + 1));
      exp_owner.push_back(2'(i % 4));
    end
    bus.req  = 4'b1111;
    bus.data = 16'h4321;
    for (int i = 0; i < 15; i++) cycle();
    chk("contention_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_owner.delete();

    // abort by dropping the winner's request
    do_reset();
    bus.req  = 4'b0100;
    bus.data = 16'h0500;
    cycle();
    chk("abort_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0000;
    cycle();
    chk("abort_ack", 32'(bus.ack), 32'h0);
    chk("abort_q",   32'(bus.q),   32'h0);
    bus.req  = 4'b0101;
    bus.data = 16'h0507;
    cycle();
    chk("abort_next_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    for (int i = 0; i < 3; i++) cycle();

    // wrap-around after a write by requester 2
    do_reset();
    bus.req  = 4'b0100;
    bus.data = 16'h0300;
    for (int i = 0; i < 3; i++) cycle();
    bus.req  = 4'b1001;
    bus.data = 16'hC00B;
    cycle();
    chk("wrap_first", 32'(bus.gnt), 32'h8);
    cycle();
    chk("wrap_q1", 32'(bus.q), 32'hC);
    cycle();
    cycle();
    chk("wrap_second", 32'(bus.gnt), 32'h1);
    cycle();
    chk("wrap_q2", 32'(bus.q), 32'hB);
    bus.req = 4'd0;
    for (int i = 0; i < 2; i++) cycle();

    // asynchronous reset while requester 1 holds the grant
    do_reset();
    bus.req  = 4'b0010;
    bus.data = 16'h00F0;
    cycle();
    chk("mid_gnt", 32'(bus.gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_gnt",  32'(bus.gnt),  32'd0);
    chk("mid_rst_ack",  32'(bus.ack),  32'd0);
    chk("mid_rst_q",    32'(bus.q),    32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.req = 4'd0;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("mid_after_q", 32'(bus.q), 32'd0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.req  = 4'($urandom_range(0, 15));
      bus.data = 16'($urandom);
      cycle();
    end
    bus.req = 4'd0;
    for (int i = 0; i < 3; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
